// File: rtl/matmul_pkg.sv
// Shared state encoding and default sizing for the matmul pass sequencer.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_N            = 3;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_MEM_DEPTH    = DEF_N * DEF_N;
  localparam int DEF_AW           = $clog2(DEF_MEM_DEPTH);
  localparam int DEF_DRAIN_CYCLES = 2 * DEF_N - 1;

  // Bits needed to hold a counter's terminal value, never less than one.
  function automatic int cnt_width(input int terminal);
    return (terminal < 2) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_tc_counter.sv
// Up-counter with synchronous clear that saturates at a terminal value.
module tc_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == WIDTH'(TERMINAL));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for one NxN matrix-multiply pass: load A and B, clear, strided feed, drain, done.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH    = N * N,
  parameter int DRAIN_CYCLES = 2 * N - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         mem_a_wr_en,
  output logic                         mem_b_wr_en,
  output logic                         mem_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_data_in,
  output logic                         sa_clear,
  output logic                         sa_en,
  output logic                         busy,
  output logic                         done
);

  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int KW  = cnt_width(N - 1);
  localparam int DCW = cnt_width(DRAIN_CYCLES - 1);

  state_t state, state_n;

  logic                  hs;
  logic [AW-1:0]         load_cnt;
  logic                  load_tc, load_clr;
  logic [KW-1:0]         feed_cnt;
  logic                  feed_tc, feed_en, feed_clr;
  logic [DCW-1:0]        drain_cnt_unused;
  logic                  drain_tc, drain_en, drain_clr;

  logic                  ready_n, a_wr_n, b_wr_n, rd_n, clr_n, en_n, busy_n, done_n;
  logic [AW-1:0]         addr_n;
  logic [DATA_WIDTH-1:0] data_n;

  // in_ready is high exactly while the state is LOAD_A or LOAD_B, so it gates the handshake.
  assign hs        = in_valid & in_ready;
  assign load_clr  = ~in_ready | (hs & load_tc);
  assign feed_en   = (state == FEED);
  assign feed_clr  = ~feed_en | feed_tc;
  assign drain_en  = (state == DRAIN);
  assign drain_clr = ~drain_en | drain_tc;

  tc_counter #(.WIDTH(AW), .TERMINAL(MEM_DEPTH - 1)) u_load_cnt (
    .clk(clk), .reset(reset), .clear(load_clr), .en(hs),
    .count(load_cnt), .tc(load_tc)
  );

  tc_counter #(.WIDTH(KW), .TERMINAL(N - 1)) u_feed_cnt (
    .clk(clk), .reset(reset), .clear(feed_clr), .en(feed_en),
    .count(feed_cnt), .tc(feed_tc)
  );

  tc_counter #(.WIDTH(DCW), .TERMINAL(DRAIN_CYCLES - 1)) u_drain_cnt (
    .clk(clk), .reset(reset), .clear(drain_clr), .en(drain_en),
    .count(drain_cnt_unused), .tc(drain_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are computed from the current state and registered, so each appears one cycle later.
  always_comb begin
    state_n = state;
    a_wr_n  = 1'b0;
    b_wr_n  = 1'b0;
    rd_n    = 1'b0;
    clr_n   = 1'b0;
    en_n    = 1'b0;
    busy_n  = 1'b1;
    done_n  = 1'b0;
    addr_n  = '0;
    data_n  = '0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) state_n = LOAD_A;
      end
      LOAD_A: begin
        a_wr_n = hs;
        if (hs) begin
          addr_n = load_cnt;
          data_n = in_data;
          if (load_tc) state_n = LOAD_B;
        end
      end
      LOAD_B: begin
        b_wr_n = hs;
        if (hs) begin
          addr_n = load_cnt;
          data_n = in_data;
          if (load_tc) state_n = CLEAR;
        end
      end
      CLEAR: begin
        clr_n   = 1'b1;
        state_n = FEED;
      end
      FEED: begin
        rd_n   = 1'b1;
        en_n   = 1'b1;
        addr_n = AW'(int'(feed_cnt) * N);
        if (feed_tc) state_n = DRAIN;
      end
      DRAIN: begin
        en_n = 1'b1;
        if (drain_tc) state_n = DONE;
      end
      DONE: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
    ready_n = (state_n == LOAD_A) || (state_n == LOAD_B);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready    <= 1'b0;
      mem_a_wr_en <= 1'b0;
      mem_b_wr_en <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      sa_clear    <= 1'b0;
      sa_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      in_ready    <= ready_n;
      mem_a_wr_en <= a_wr_n;
      mem_b_wr_en <= b_wr_n;
      mem_rd_en   <= rd_n;
      mem_addr    <= addr_n;
      mem_data_in <= data_n;
      sa_clear    <= clr_n;
      sa_en       <= en_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized self-checking bench for matmul_seq_ctrl against a pass-level transaction model.
module tb_matmul_seq_ctrl;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int DEPTH = N * N;
  localparam int AW    = $clog2(DEPTH);
  localparam int DRAIN = 2 * N - 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_a_wr_en;
  logic          mem_b_wr_en;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          sa_clear;
  logic          sa_en;
  logic          busy;
  logic          done;
  logic [19:0]   out_vec;

  typedef struct packed {
    logic          ready;
    logic          wa;
    logic          wb;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          clr;
    logic          en;
    logic          busy;
    logic          done;
  } obs_t;

  obs_t          trace[$];
  logic [DW-1:0] sent_a[DEPTH];
  logic [DW-1:0] sent_b[DEPTH];
  int            checks   = 0;
  int            failures = 0;

  matmul_seq_ctrl #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_a_wr_en(mem_a_wr_en), .mem_b_wr_en(mem_b_wr_en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .sa_clear(sa_clear), .sa_en(sa_en), .busy(busy), .done(done)
  );

  assign out_vec = {in_ready, mem_a_wr_en, mem_b_wr_en, mem_rd_en, mem_addr, mem_data_in,
                    sa_clear, sa_en, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle's outputs are logged on the falling edge for later pass-level analysis.
  always @(negedge clk) begin
    obs_t o;
    o.ready = in_ready;
    o.wa    = mem_a_wr_en;
    o.wb    = mem_b_wr_en;
    o.rd    = mem_rd_en;
    o.addr  = mem_addr;
    o.data  = mem_data_in;
    o.clr   = sa_clear;
    o.en    = sa_en;
    o.busy  = busy;
    o.done  = done;
    trace.push_back(o);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Offers one element and waits (bounded) for the controller to take it.
  task automatic sendElem(input logic [DW-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("handshake", ok, 1);
  endtask

  // Reduces a window of the output log to the pass-level facts the model predicts.
  task automatic analyzePass(input int from, input int to, input int exp_gap);
    int na = 0, nb = 0, nr = 0, nclr = 0, nen = 0, ndone = 0, viol = 0, busy_after = 0;
    int last_wr = -1, clr_at = -1, first_rd = -1, first_en = -1, last_en = -1, done_at = -1;
    int wa4_at = -1, wa5_at = -1;
    for (int i = from; i < to; i++) begin
      obs_t o;
      o = trace[i];
      if (o.wa && o.wb) viol++;
      if ((o.wa || o.wb) && o.rd) viol++;
      if ((o.wa || o.wb || o.rd) && (int'(o.addr) > DEPTH - 1)) viol++;
      if (o.wa) begin
        if (na == 4) wa4_at = i;
        if (na == 5) wa5_at = i;
        if (na < DEPTH) begin
          checkOutput("wr_a_addr", o.addr, na);
          checkOutput("wr_a_data", o.data, sent_a[na]);
        end
        na++;
        last_wr = i;
      end
      if (o.wb) begin
        if (na != DEPTH) viol++;
        if (nb < DEPTH) begin
          checkOutput("wr_b_addr", o.addr, nb);
          checkOutput("wr_b_data", o.data, sent_b[nb]);
        end
        nb++;
        last_wr = i;
      end
      if (o.clr) begin
        nclr++;
        clr_at = i;
      end
      if (o.rd) begin
        if (nr < N) checkOutput("rd_addr", o.addr, nr * N);
        if (first_rd < 0) first_rd = i;
        nr++;
      end
      if (o.en) begin
        nen++;
        if (first_en < 0) first_en = i;
        last_en = i;
      end
      if (o.done) begin
        ndone++;
        done_at = i;
        checkOutput("done_busy", o.busy, 0);
      end else if (done_at >= 0 && o.busy) begin
        busy_after++;
      end
    end
    checkOutput("invariants", viol, 0);
    checkOutput("wr_a_count", na, DEPTH);
    checkOutput("wr_b_count", nb, DEPTH);
    checkOutput("clr_count", nclr, 1);
    checkOutput("clr_after_wr", clr_at > last_wr, 1);
    if (last_wr >= 0) checkOutput("ready_drop", trace[last_wr].ready, 0);
    checkOutput("rd_count", nr, N);
    checkOutput("rd_after_clr", first_rd - clr_at, 1);
    checkOutput("sa_en_cycles", nen, N + DRAIN);
    checkOutput("sa_en_span", last_en - first_en + 1, N + DRAIN);
    checkOutput("sa_en_start", first_en - clr_at, 1);
    checkOutput("done_count", ndone, 1);
    checkOutput("done_after_drain", done_at - last_en, 1);
    if (done_at > from) checkOutput("busy_before_done", trace[done_at - 1].busy, 1);
    checkOutput("busy_after_done", busy_after, 0);
    if (exp_gap > 0) checkOutput("stall_gap", wa5_at - wa4_at, exp_gap);
  endtask

  // Runs one complete pass with optional stalls, start pokes and start held for back-to-back.
  task automatic applyStimulus(input bit seq_data, input int stall_after, input int stall_len,
                               input bit rand_stall, input bit hold_start, input bit poke_start,
                               input int tail, input int exp_gap);
    int from;
    bit got;
    @(posedge clk);
    #1;
    from = trace.size();
    for (int i = 0; i < DEPTH; i++) begin
      sent_a[i] = seq_data ? DW'(i + 1) : DW'($urandom);
      sent_b[i] = seq_data ? DW'(i + 1 + DEPTH) : DW'($urandom);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (rand_stall && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      sendElem(i < DEPTH ? sent_a[i] : sent_b[i - DEPTH]);
      if (i + 1 == stall_after) begin
        repeat (stall_len) @(posedge clk);
        #1;
      end
    end
    if (poke_start) begin
      got = 1'b0;
      for (int g = 0; g < 40 && !got; g++) begin
        @(negedge clk);
        got = mem_rd_en;
      end
      checkOutput("feed_seen", got, 1);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int g = 0; g < 60 && !got; g++) begin
      @(negedge clk);
      got = done;
    end
    checkOutput("done_seen", got, 1);
    @(posedge clk);
    #1;
    repeat (tail) @(posedge clk);
    analyzePass(from, trace.size(), exp_gap);
    if (hold_start) begin
      @(negedge clk);
      checkOutput("b2b_ready", in_ready, 1);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    reset    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", out_vec, 0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_ready", in_ready, 0);

    $display("[TB] directed pass A=1..9 B=10..18");
    applyStimulus(1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 4, 0);

    $display("[TB] stall after A element 5");
    applyStimulus(1'b1, 5, 4, 1'b0, 1'b0, 1'b0, 4, 5);

    $display("[TB] start pulsed during FEED");
    applyStimulus(1'b0, -1, 0, 1'b0, 1'b0, 1'b1, 12, 0);

    $display("[TB] reset during LOAD_B");
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) sendElem(DW'($urandom));
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_outputs", out_vec, 0);
    @(negedge clk);
    checkOutput("abort_hold", out_vec, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_idle", {busy, in_ready}, 0);
    applyStimulus(1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 4, 0);

    $display("[TB] back-to-back passes with start held");
    applyStimulus(1'b0, -1, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 4, 0);

    $display("[TB] randomized passes");
    for (int p = 0; p < 3; p++) applyStimulus(1'b0, -1, 0, 1'b1, 1'b0, 1'b0, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
